// File: rtl/image_pkg.sv
// ---------------------------------------------------------------------------
// image_pkg
// Shared definitions for the image streaming transmitter.
//   IMG_W / IMG_H       : image dimensions in pixels
//   COORD_X_W/COORD_Y_W : coordinate widths derived from the dimensions (4)
//   SYNC_BYTE_DEFAULT   : default frame-start marker byte
//   tx_state_t          : transmit FSM states
//   pix_entry_t         : one queued pixel {sof, eof, data}
// ---------------------------------------------------------------------------
package image_pkg;

    localparam int IMG_W     = 16;
    localparam int IMG_H     = 16;
    localparam int COORD_X_W = $clog2(IMG_W);
    localparam int COORD_Y_W = $clog2(IMG_H);

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_CHK
    } tx_state_t;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] data;
    } pix_entry_t;

    localparam int ENTRY_W = $bits(pix_entry_t);

    // The frame starts at the top-left pixel.
    function automatic logic is_origin(input logic [COORD_X_W-1:0] x,
                                       input logic [COORD_Y_W-1:0] y);
        return (x == '0) && (y == '0);
    endfunction

endpackage

// File: rtl/image_stream_tx_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head read (first-word fall-through
// from registered storage).
//   clk, nrst   : clock, asynchronous active-low reset
//   clear       : synchronous flush, wins over push/pop
//   push, wdata : write request; ignored while full
//   pop         : read request; ignored while empty
//   full, empty : occupancy flags
//   head        : entry at the read pointer
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full && !clear;
    assign w_do_pop  = pop && !empty && !clear;

    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;  // idle, or push and pop cancel out
            endcase
        end
    end

endmodule

// File: rtl/image_stream_tx.sv
// ---------------------------------------------------------------------------
// image_stream_tx
// Queues pixels from the image controller and serialises each frame as
// SYNC_BYTE, data bytes, 8-bit checksum over a valid/ready byte interface.
//   clk, nrst    : clock, asynchronous active-low reset
//   clear        : synchronous flush of FIFO, FSM, checksum and drop flag
//   pixel_*      : upstream pixel interface (valid/ready, x, y, data, last)
//   tx_valid/tx_data/tx_ready : downstream byte interface
//   frame_done   : one-cycle pulse after the checksum byte transfers
//   dropped      : sticky, a pixel was offered while the FIFO was full
// ---------------------------------------------------------------------------
module image_stream_tx
    import image_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clear,
    input  logic                 pixel_valid,
    input  logic [COORD_X_W-1:0] pixel_x,
    input  logic [COORD_Y_W-1:0] pixel_y,
    input  logic [7:0]           pixel_data,
    input  logic                 pixel_last,
    output logic                 pixel_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 frame_done,
    output logic                 dropped
);

    tx_state_t  r_state;
    logic [7:0] r_csum;
    logic       r_in_frame;  // at least one data byte of this frame sent
    logic       r_frame_done;
    logic       r_dropped;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_xfer;
    pix_entry_t w_wr_entry;
    pix_entry_t w_head;

    assign w_wr_entry  = {is_origin(pixel_x, pixel_y), pixel_last, pixel_data};
    assign w_push      = pixel_valid;  // FIFO itself refuses when full
    assign w_xfer      = tx_valid && tx_ready;
    assign w_pop       = (r_state == ST_DATA) && w_xfer;
    assign pixel_ready = !w_full;
    assign frame_done  = r_frame_done;
    assign dropped     = r_dropped;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .clear (clear),
        .push  (w_push),
        .wdata (w_wr_entry),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // Byte presented downstream is a pure decode of registered state and
    // registered FIFO storage, so it holds while the receiver stalls.
    // NOTE: defaults first so no path through the case leaves an output
    // unassigned, which would infer a latch.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (r_state)
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
            end
            ST_DATA: begin
                // A new frame's first pixel behind an unterminated frame is
                // held back until SYNC has been emitted for it.
                tx_valid = !w_empty && !(w_head.sof && r_in_frame);
                tx_data  = w_head.data;
            end
            ST_CHK: begin
                tx_valid = 1'b1;
                tx_data  = r_csum;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ST_IDLE;
            r_csum       <= 8'h00;
            r_in_frame   <= 1'b0;
            r_frame_done <= 1'b0;
            r_dropped    <= 1'b0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_csum       <= 8'h00;
            r_in_frame   <= 1'b0;
            r_frame_done <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (pixel_valid && w_full) r_dropped <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_in_frame <= 1'b0;
                    if (!w_empty) r_state <= w_head.sof ? ST_SYNC : ST_DATA;
                end
                ST_SYNC: begin
                    r_csum     <= 8'h00;
                    r_in_frame <= 1'b0;
                    if (w_xfer) r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_csum     <= r_csum + w_head.data;  // wraps mod 256
                        r_in_frame <= 1'b1;
                        if (w_head.eof) r_state <= ST_CHK;
                    end else if (!w_empty && w_head.sof && r_in_frame) begin
                        r_state <= ST_SYNC;
                    end
                end
                ST_CHK: begin
                    if (w_xfer) begin
                        r_frame_done <= 1'b1;
                        r_csum       <= 8'h00;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_image_stream_tx
// Scoreboard bench: every accepted pixel is expanded by a frame-level model
// (SYNC on a frame start, the data byte, checksum on the last pixel) into a
// queue of expected bytes; a monitor pops and compares on each transfer.
// ---------------------------------------------------------------------------
module tb_image_stream_tx;

    localparam int         DEPTH = 8;
    localparam logic [7:0] SYNC  = 8'hA5;

    typedef struct {
        logic [7:0] data;
        bit         is_chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic       clear;
    logic       pixel_valid;
    logic [3:0] pixel_x;
    logic [3:0] pixel_y;
    logic [7:0] pixel_data;
    logic       pixel_last;
    logic       pixel_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic       frame_done;
    logic       dropped;

    int   total = 0;
    int   bad   = 0;
    int   tx_mode = 1;  // 0: stall, 1: always ready, 2: random
    exp_t sb[$];
    logic [7:0] m_csum = 8'h00;

    image_stream_tx #(
        .FIFO_DEPTH (DEPTH),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .clear       (clear),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_data  (pixel_data),
        .pixel_last  (pixel_last),
        .pixel_ready (pixel_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .frame_done  (frame_done),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (tx_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: what the link must carry for an accepted pixel.
    task automatic model_pixel(input logic [3:0] x, input logic [3:0] y,
                               input logic [7:0] d, input bit last);
        if (x == 4'd0 && y == 4'd0) begin
            sb.push_back('{data: SYNC, is_chk: 1'b0});
            m_csum = 8'h00;
        end
        sb.push_back('{data: d, is_chk: 1'b0});
        m_csum = m_csum + d;
        if (last) sb.push_back('{data: m_csum, is_chk: 1'b1});
    endtask

    // Called and returns at posedge+1.
    task automatic offer(input logic [3:0] x, input logic [3:0] y, input logic [7:0] d,
                         input bit last, input bit retry, output bit acc);
        int n = 0;
        pixel_valid = 1'b1;
        pixel_x     = x;
        pixel_y     = y;
        pixel_data  = d;
        pixel_last  = last;
        do begin
            @(negedge clk);
            acc = pixel_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && retry && n < 200);
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        if (acc) model_pixel(x, y, d, last);
        else if (retry) check("offer_timeout", 32'(n), 32'd0);
    endtask

    task automatic send(input logic [3:0] x, input logic [7:0] d, input bit last);
        bit acc;
        offer(x, 4'd0, d, last, 1'b1, acc);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: byte order, stall stability and frame_done timing.
    bit         hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         exp_fd = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!nrst || clear) begin
            hold   = 1'b0;
            exp_fd = 1'b0;
        end else begin
            if (hold) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(hold_data));
            end
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            exp_fd = 1'b0;
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(e.data));
                    exp_fd = e.is_chk;
                end
            end
            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    task automatic check_reset_outputs(input string name);
        check({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
        check({name, "_tx_data"}, 32'(tx_data), 32'h00);
        check({name, "_frame_done"}, 32'(frame_done), 32'd0);
        check({name, "_dropped"}, 32'(dropped), 32'd0);
        check({name, "_pixel_ready"}, 32'(pixel_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        nrst = 1'b1; clear = 1'b0; pixel_valid = 1'b0;
        pixel_x = '0; pixel_y = '0; pixel_data = '0; pixel_last = 1'b0;
        #1 nrst = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;

        // Basic frame, with first-byte latency: accepted in N, SYNC in N+2.
        tx_mode = 1;
        @(posedge clk); #1;
        offer(4'd0, 4'd0, 8'h10, 1'b0, 1'b0, acc);
        check("lat_accept", 32'(acc), 32'd1);
        @(negedge clk);
        check("lat_n1_valid", 32'(tx_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_n2_valid", 32'(tx_valid), 32'd1);
        check("lat_n2_sync", 32'(tx_data), 32'(SYNC));
        @(posedge clk); #1;
        send(4'd1, 8'h20, 1'b0);
        send(4'd2, 8'h30, 1'b1);
        wait_drain("basic", 50);

        // Single-pixel frame: SYNC, data, checksum equal to data.
        send(4'd0, 8'h5C, 1'b1);
        wait_drain("single", 50);

        // Stall during DATA.
        send(4'd0, 8'h41, 1'b0);
        send(4'd1, 8'h42, 1'b0);
        send(4'd2, 8'h43, 1'b0);
        tx_mode = 0;
        repeat (5) @(posedge clk);
        #1 tx_mode = 1;
        send(4'd3, 8'h44, 1'b1);
        wait_drain("stall", 50);

        // Overflow: 8 fill the FIFO, the 9th is discarded and flagged.
        tx_mode = 0;
        for (int i = 0; i < DEPTH; i++) begin
            offer(4'(i), 4'd0, 8'(8'h80 + i), (i == DEPTH - 1), 1'b0, acc);
            check("fill_accept", 32'(acc), 32'd1);
        end
        check("full_ready", 32'(pixel_ready), 32'd0);
        offer(4'd0, 4'd0, 8'h99, 1'b0, 1'b0, acc);
        check("full_reject", 32'(acc), 32'd0);
        check("dropped_set", 32'(dropped), 32'd1);
        tx_mode = 1;
        wait_drain("overflow", 100);
        check("dropped_sticky", 32'(dropped), 32'd1);

        // Clear abandons queued pixels and beats a same-cycle push.
        tx_mode = 0;
        send(4'd0, 8'h61, 1'b0);
        send(4'd1, 8'h62, 1'b0);
        send(4'd2, 8'h63, 1'b0);
        clear = 1'b1;
        pixel_valid = 1'b1; pixel_x = 4'd0; pixel_y = 4'd0;
        pixel_data = 8'h77; pixel_last = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        clear = 1'b0; pixel_valid = 1'b0; pixel_last = 1'b0;
        check("clear_dropped", 32'(dropped), 32'd0);
        check("clear_ready", 32'(pixel_ready), 32'd1);
        tx_mode = 1;
        repeat (4) @(posedge clk);
        #1;
        send(4'd0, 8'h01, 1'b0);
        send(4'd1, 8'h02, 1'b1);
        wait_drain("after_clear", 50);

        // Checksum wrap: FF+FF+03 = 01.
        send(4'd0, 8'hFF, 1'b0);
        send(4'd1, 8'hFF, 1'b0);
        send(4'd2, 8'h03, 1'b1);
        check("wrap_model_chk", 32'(sb[sb.size()-1].data), 32'h01);
        wait_drain("wrap", 50);

        // Back-to-back frames.
        send(4'd0, 8'h11, 1'b0);
        send(4'd1, 8'h22, 1'b1);
        send(4'd0, 8'h33, 1'b0);
        send(4'd1, 8'h44, 1'b0);
        send(4'd2, 8'h55, 1'b1);
        wait_drain("b2b", 80);

        // Asynchronous reset mid-DATA with 4 pixels queued.
        tx_mode = 0;
        for (int i = 0; i < 5; i++) send(4'(i), 8'(8'hC0 + i), 1'b0);
        tx_mode = 1;
        repeat (2) @(posedge clk);
        #1 tx_mode = 0;
        #2 nrst = 1'b0;
        sb.delete();
        #1 check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        tx_mode = 1;
        send(4'd0, 8'hD1, 1'b0);
        send(4'd1, 8'hD2, 1'b1);
        wait_drain("post_reset", 50);

        // Randomised frames with random backpressure and input gaps.
        tx_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int len = $urandom_range(1, 12);
            for (int p = 0; p < len; p++) begin
                bit a;
                offer(4'(p % 16), 4'(p / 16), 8'($urandom), (p == len - 1), 1'b1, a);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_drain("random", 3000);
        tx_mode = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
